// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state, opcode and phase constants for the fetch/execute path
package seq_pkg;

  // Sequencer states, shared with debug and the control generator
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    READ = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_e;

  // Opcodes understood by the decoder
  localparam logic [3:0] INC_B   = 4'h0;
  localparam logic [3:0] MOV_AB  = 4'h1;
  localparam logic [3:0] MOV_BA  = 4'h2;
  localparam logic [3:0] INC_A   = 4'h3;
  localparam logic [3:0] HALT_OP = 4'hF;

  // Execute-phase strobes T0..T3
  localparam int EXEC_PHASES = 4;

  // First execute strobe (T0)
  function automatic logic [EXEC_PHASES-1:0] first_phase();
    return {{(EXEC_PHASES-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_sequencer_phase_ring.sv
// rtl/fetch_sequencer_phase_ring.sv - one-hot execute-phase ring with load and clear
import seq_pkg::*;

module phase_ring (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic                   advance,
  output logic [EXEC_PHASES-1:0] phase,
  output logic                   wrap
);

  // Clear dominates load, load dominates rotation
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase <= '0;
    end else if (load) begin
      phase <= first_phase();
    end else if (advance) begin
      phase <= {phase[EXEC_PHASES-2:0], phase[EXEC_PHASES-1]};
    end
  end

  // Last phase marks the instruction boundary
  assign wrap = phase[EXEC_PHASES-1];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/MAR/IR fetch-execute sequencer; HALT_OPCODE_EN makes opcode all-ones halt
import seq_pkg::*;

module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [3:0]        exec_phase,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_ADDR = ADDR;
  localparam logic [2:0] S_READ = READ;
  localparam logic [2:0] S_EXEC = EXEC;
  localparam logic [2:0] S_HALT = HALT;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic              fetch_done;
  logic              boundary;
  logic              op_halt;
  logic              wrap;
  logic [3:0]        phase;

  // An acknowledged read completes the fetch; only READ listens to mem_ack
  assign fetch_done = (state == S_READ) && mem_ack;
  // Last execute phase of the current instruction
  assign boundary   = (state == S_EXEC) && wrap;

`ifdef HALT_OPCODE_EN
  assign op_halt = (ir == {DATA_W{1'b1}});
`else
  assign op_halt = 1'b0;
`endif

  // Next-state selection; halt and run only matter at the boundary
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_READ;
      S_READ: if (mem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (wrap) begin
          if (halt_req || op_halt) state_nxt = S_HALT;
          else if (run)            state_nxt = S_ADDR;
          else                     state_nxt = S_IDLE;
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // PC, MAR and IR datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      mar  <= '0;
      ir   <= '0;
    end else begin
      if (state == S_ADDR) mar <= pc_q;
      if (fetch_done) begin
        ir   <= mem_rdata;
        pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

  // Read request raised on entry to READ and held until acknowledged
  always_ff @(posedge clk) begin
    if (rst)                  mem_rd <= 1'b0;
    else if (state == S_ADDR) mem_rd <= 1'b1;
    else if (fetch_done)      mem_rd <= 1'b0;
  end

  // instr_valid tracks EXEC and moves on the same edge as the phase ring
  always_ff @(posedge clk) begin
    if (rst)             instr_valid <= 1'b0;
    else if (fetch_done) instr_valid <= 1'b1;
    else if (boundary)   instr_valid <= 1'b0;
  end

  phase_ring u_phase_ring (
    .clk     (clk),
    .rst     (rst),
    .load    (fetch_done),
    .clear   (boundary),
    .advance (state == S_EXEC),
    .phase   (phase),
    .wrap    (wrap)
  );

  assign mem_addr   = mar;
  assign instr      = ir;
  assign exec_phase = phase;
  assign pc         = pc_q;
  assign halted     = (state == S_HALT);

endmodule
